// File: rtl/sblk_pipe.sv
// -----------------------------------------------------------------------------
// sblk_pipe
//   Generic aligned delay line. Stage 0 combines operands a and b with a
//   bitwise function selected by MODE. The result then travels through DEPTH
//   registered stages. Each stage carries its own valid bit. The pipeline
//   can be stalled (en=0) or cleared synchronously (flush=1), and it reports
//   how many stages currently hold a valid word.
//
//   Parameters
//     WIDTH  data width of a, b and q
//     DEPTH  number of register stages (>= 1)
//     MODE   stage-0 function: 0 a&b, 1 a|b, 2 a^b, 3 a (b ignored)
//     CW     width of count, derived from DEPTH
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset
//     a, b      in   operands, WIDTH bits
//     in_valid  in   operands valid this cycle
//     en        in   advance the pipeline; 0 holds all state
//     flush     in   synchronous clear of every stage (wins over en)
//     q         out  last-stage data, forced to 0 when not valid
//     q_valid   out  last-stage valid
//     count     out  number of stages holding valid data
// -----------------------------------------------------------------------------
module sblk_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  parameter  int MODE  = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] f;

  // The stage-0 function is purely bitwise, so there are no carries and the
  // width does not grow.
  always_comb begin
    case (MODE)
      0:       f = a & b;
      1:       f = a | b;
      2:       f = a ^ b;
      default: f = a;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so that no path
    // leaves one unassigned and no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      valid_d = '0;
      count_d = '0;
    end else if (en) begin
      // Words that are not valid are loaded as zero. This keeps q at 0
      // whenever q_valid is low, with no masking needed at the output.
      data_d[0]  = in_valid ? f : '0;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // One word may enter and one may leave on the same edge. When the
      // pipeline is full and a word enters, the last stage is necessarily
      // valid and leaves, so count never goes past DEPTH. When count is 0,
      // nothing leaves, so count never drops below 0.
      count_d = count_q + CW'(in_valid) - CW'(valid_q[DEPTH-1]);
    end
  end

  // NOTE: the stage array is reset along with the valid bits, because an
  // asynchronous reset must clear in-flight data. It must not only
  // invalidate that data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every stage samples
      // the value its predecessor held before this edge.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;

endmodule

// File: tb/tb_sblk_pipe.sv
// -----------------------------------------------------------------------------
// tb_sblk_pipe
//   Directed bench for sblk_pipe. It drives two instances from the same
//   inputs:
//     u_d2  default configuration (WIDTH=8, DEPTH=2, MODE=0, a&b)
//     u_d4  DEPTH=4, MODE=2 (a^b), used for streaming and mid-stream reset
//   Inputs change just after a falling edge. Outputs are sampled on the
//   falling edge, after the rising edge under test.
// -----------------------------------------------------------------------------
module tb_sblk_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       in_valid, en, flush;

  logic [7:0] q2, q4;
  logic       qv2, qv4;
  logic [1:0] cnt2;
  logic [2:0] cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sblk_pipe u_d2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .en(en), .flush(flush), .q(q2), .q_valid(qv2), .count(cnt2)
  );

  sblk_pipe #(.WIDTH(8), .DEPTH(4), .MODE(2)) u_d4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .en(en), .flush(flush), .q(q4), .q_valid(qv4), .count(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then move to the following falling edge for sampling.
  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // ---- 1. Reset holds everything at zero, even with live inputs ----
    rst_n = 1'b0; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; en = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("reset_q", q2, 0);
      check("reset_qv", qv2, 0);
      check("reset_cnt", cnt2, 0);
    end
    check("reset_cnt4", cnt4, 0);
    rst_n = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
    edge_step();
    check("idle_qv", qv2, 0);

    // ---- 2. Latency: F0 & 3C = 30, out after 2 edges, count 1,1,0 ----
    a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    edge_step();
    in_valid = 1'b0;
    check("lat_e1_qv", qv2, 0);
    check("lat_e1_cnt", cnt2, 1);
    edge_step();
    check("lat_e2_q", q2, 8'h30);
    check("lat_e2_qv", qv2, 1);
    check("lat_e2_cnt", cnt2, 1);
    edge_step();
    check("lat_e3_q", q2, 0);
    check("lat_e3_qv", qv2, 0);
    check("lat_e3_cnt", cnt2, 0);

    // ---- 3. Stall: fill with 11, 22, then hold for 3 cycles ----
    b = 8'hFF; in_valid = 1'b1; a = 8'h11;
    edge_step();
    a = 8'h22;
    edge_step();
    check("fill_q", q2, 8'h11);
    check("fill_cnt", cnt2, 2);
    en = 1'b0; a = 8'h77;   // in_valid stays high: stalled words must be lost
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("stall_q", q2, 8'h11);
      check("stall_qv", qv2, 1);
      check("stall_cnt", cnt2, 2);
    end
    // Resume with no new input: 22 must follow, and no 77 after it.
    en = 1'b1; in_valid = 1'b0;
    edge_step();
    check("resume_q", q2, 8'h22);
    check("resume_cnt", cnt2, 1);
    edge_step();
    check("resume_drain_qv", qv2, 0);
    check("resume_drain_q", q2, 0);
    check("resume_drain_cnt", cnt2, 0);

    // ---- 4. Flush with en=0 and in_valid=1 drops everything ----
    in_valid = 1'b1; a = 8'h44;
    edge_step();
    a = 8'h66;
    edge_step();
    check("pre_flush_cnt", cnt2, 2);
    flush = 1'b1; en = 1'b0; a = 8'h55;
    edge_step();
    check("flush_qv", qv2, 0);
    check("flush_q", q2, 0);
    check("flush_cnt", cnt2, 0);
    flush = 1'b0; en = 1'b1; in_valid = 1'b0; a = 8'h00;
    for (int i = 0; i < 2; i++) begin
      edge_step();
      check("post_flush_qv", qv2, 0);
      check("post_flush_cnt", cnt2, 0);
    end
    check("post_flush_cnt4", cnt4, 0);

    // ---- 5. Streaming 10 words a=i, b=FF ----
    // u_d4 must output ~i from edge 4 on, and u_d2 must output i from edge 2 on.
    b = 8'hFF; in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      a = 8'(k - 1);
      edge_step();
      if (k >= 4) begin
        check("s4_q", q4, {24'h0, ~8'(k - 4)});
        check("s4_qv", qv4, 1);
        check("s4_cnt", cnt4, 4);
      end else begin
        check("s4_fill_qv", qv4, 0);
        check("s4_fill_cnt", cnt4, k);
      end
      if (k >= 2) begin
        check("s2_q", q2, k - 2);
        check("s2_cnt", cnt2, 2);
      end
    end
    in_valid = 1'b0; a = 8'h00;
    edge_step();                 // edge 11: word 7 out, 3 still in flight
    check("drain_q4", q4, 8'hF8);
    check("drain_cnt4", cnt4, 3);
    check("drain_q2", q2, 8'h09);
    check("drain_cnt2", cnt2, 1);

    // ---- 6. Async reset between edges with count=3 ----
    #2 rst_n = 1'b0;
    #1;
    check("areset_q4", q4, 0);
    check("areset_qv4", qv4, 0);
    check("areset_cnt4", cnt4, 0);
    check("areset_cnt2", cnt2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Refill from empty: one word, 05 ^ FF = FA, arrives 4 edges later.
    a = 8'h05; b = 8'hFF; in_valid = 1'b1;
    edge_step();
    in_valid = 1'b0;
    check("refill_cnt4", cnt4, 1);
    check("refill_qv4", qv4, 0);
    edge_step();
    edge_step();
    check("refill_e3_qv4", qv4, 0);
    edge_step();
    check("refill_q4", q4, 8'hFA);
    check("refill_qv4_out", qv4, 1);
    check("refill_cnt4_out", cnt4, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
